attack_judge: RTL

//  Attack-phase scorer feeding the fight-screen renderer. On a UART attack key it latches the

---
 rtl/attack_judge.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/attack_judge.sv
// attack_judge: attack-phase scorer for the fight screen.
//   When an attack key arrives over UART, the moving-bar x position is latched
//   and classified against the score-bar zones. The matching damage is then
//   applied to the monster HP register, which saturates at zero. A cooldown
//   counted in animation frames must expire before the next attack is taken.
//   The restart key restores full HP from any state.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_rx_receive    one-cycle strobe qualifying i_rx_data
//   i_rx_data       received UART byte
//   i_animate       one-cycle end-of-frame strobe
//   i_bar_x         moving-bar centre x in pixels
//   o_monster_hp    remaining monster HP (registered)
//   o_zone          last judged zone: 0 miss, 1 blue, 2 orange, 3 yellow, 4 green
//   o_damage        damage of the last judged attack
//   o_hit_valid     one-cycle pulse when o_monster_hp takes an attack result
//   o_busy          high in JUDGE, APPLY and COOLDOWN
//   o_dead          high when o_monster_hp == 0
module attack_judge #(
  parameter logic [15:0] MAX_HP          = 16'd500,
  parameter logic [15:0] DMG_GREEN       = 16'd50,
  parameter logic [15:0] DMG_YELLOW      = 16'd30,
  parameter logic [15:0] DMG_ORANGE      = 16'd15,
  parameter logic [15:0] DMG_BLUE        = 16'd5,
  parameter logic [7:0]  COOLDOWN_FRAMES = 8'd30,
  parameter logic [7:0]  ATTACK_KEY      = 8'h20,
  parameter logic [7:0]  RESTART_KEY     = 8'h72
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_receive,
  input  logic [7:0]  i_rx_data,
  input  logic        i_animate,
  input  logic [15:0] i_bar_x,
  output logic [15:0] o_monster_hp,
  output logic [2:0]  o_zone,
  output logic [15:0] o_damage,
  output logic        o_hit_valid,
  output logic        o_busy,
  output logic        o_dead
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    JUDGE    = 3'd1,
    APPLY    = 3'd2,
    COOLDOWN = 3'd3,
    DEAD     = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [15:0] bar_x_lat, bar_x_lat_nx;
  logic [15:0] hp_nx, damage_nx;
  logic [2:0]  zone_nx, judged_zone;
  logic [7:0]  cnt, cnt_nx;
  logic        hit_nx, busy_nx, dead_nx;
  logic        attack_key, restart_key;

  // Zone lookup on the latched x; anything outside the listed windows
  // (including off-screen x) is a miss.
  function automatic logic [2:0] classify(input logic [15:0] x);
    if (x >= 16'd305 && x <= 16'd325) begin
      classify = 3'd4;
    end else if ((x >= 16'd220 && x <= 16'd235) || (x >= 16'd395 && x <= 16'd410)) begin
      classify = 3'd3;
    end else if ((x >= 16'd160 && x <= 16'd175) || (x >= 16'd455 && x <= 16'd470)) begin
      classify = 3'd2;
    end else if ((x >= 16'd115 && x <= 16'd130) || (x >= 16'd500 && x <= 16'd515)) begin
      classify = 3'd1;
    end else begin
      classify = 3'd0;
    end
  endfunction

  function automatic logic [15:0] zone_damage(input logic [2:0] z);
    case (z)
      3'd4:    zone_damage = DMG_GREEN;
      3'd3:    zone_damage = DMG_YELLOW;
      3'd2:    zone_damage = DMG_ORANGE;
      3'd1:    zone_damage = DMG_BLUE;
      default: zone_damage = 16'd0;
    endcase
  endfunction

  assign attack_key  = i_rx_receive && (i_rx_data == ATTACK_KEY);
  assign restart_key = i_rx_receive && (i_rx_data == RESTART_KEY);
  assign judged_zone = classify(bar_x_lat);

  // Next-state and next-output computation; restart overrides everything.
  always_comb begin
    state_nx     = state;
    bar_x_lat_nx = bar_x_lat;
    hp_nx        = o_monster_hp;
    zone_nx      = o_zone;
    damage_nx    = o_damage;
    cnt_nx       = cnt;
    hit_nx       = 1'b0;

    if (restart_key) begin
      hp_nx     = MAX_HP;
      zone_nx   = 3'd0;
      damage_nx = 16'd0;
      cnt_nx    = 8'd0;
      state_nx  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (attack_key) begin
            bar_x_lat_nx = i_bar_x;
            state_nx     = JUDGE;
          end else begin
            state_nx = IDLE;
          end
        end
        JUDGE: begin
          zone_nx   = judged_zone;
          damage_nx = zone_damage(judged_zone);
          state_nx  = APPLY;
        end
        APPLY: begin
          // Full-width compare so a large hit clamps to zero instead of wrapping.
          if (o_monster_hp > o_damage) begin
            hp_nx = o_monster_hp - o_damage;
          end else begin
            hp_nx = 16'd0;
          end
          hit_nx   = 1'b1;
          cnt_nx   = COOLDOWN_FRAMES;
          state_nx = COOLDOWN;
        end
        COOLDOWN: begin
          if (cnt == 8'd0) begin
            if (o_monster_hp == 16'd0) begin
              state_nx = DEAD;
            end else begin
              state_nx = IDLE;
            end
          end else if (i_animate) begin
            cnt_nx = cnt - 8'd1;
          end else begin
            cnt_nx = cnt;
          end
        end
        DEAD: begin
          state_nx = DEAD;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end

    busy_nx = (state_nx == JUDGE) || (state_nx == APPLY) || (state_nx == COOLDOWN);
    dead_nx = (hp_nx == 16'd0);
  end

  // State and registered outputs; o_busy/o_dead track the next state and HP
  // so they change on the same edge as the values they describe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      bar_x_lat    <= 16'd0;
      cnt          <= 8'd0;
      o_monster_hp <= MAX_HP;
      o_zone       <= 3'd0;
      o_damage     <= 16'd0;
      o_hit_valid  <= 1'b0;
      o_busy       <= 1'b0;
      o_dead       <= 1'b0;
    end else begin
      state        <= state_nx;
      bar_x_lat    <= bar_x_lat_nx;
      cnt          <= cnt_nx;
      o_monster_hp <= hp_nx;
      o_zone       <= zone_nx;
      o_damage     <= damage_nx;
      o_hit_valid  <= hit_nx;
      o_busy       <= busy_nx;
      o_dead       <= dead_nx;
    end
  end

endmodule
